// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encodings and ACK/NACK bus levels for slave and master.
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GETADDR  = 4'd1,
    ADDRACK  = 4'd2,
    GETDATA  = 4'd3,
    DATAACK  = 4'd4,
    SENDDATA = 4'd5,
    GETACK   = 4'd6,
    WAITSTOP = 4'd7
  } i2c_state_e;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop synchroniser for one bus line plus rise/fall strobes of the synchronised value.
module i2c_bus_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  assign sh_d = {sh_q[1:0], d};
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) sh_q <= '1;
    else      sh_q <= sh_d;
  assign q    = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/i2c_slave_target.sv
// i2c_slave_target: I2C slave, LSB-first address/data, RorW=1 means master writes.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the all-zero address for writes.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter int          ADDRESSLENGTH = 7,
  parameter int unsigned OWN_ADDRESS   = 'h2A
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl,
  inout  wire        Sda,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  input  logic [7:0] TxData,
  output logic       TxReq,
  output logic       Addressed,
  output logic [3:0] State
);
  localparam logic [ADDRESSLENGTH-1:0] OWN = OWN_ADDRESS[ADDRESSLENGTH-1:0];
  logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall;
  logic start_det, stop_det, addr_match;
  logic [7:0] rx_next;
  i2c_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, tx_byte_q, tx_byte_d;
  logic [ADDRESSLENGTH-1:0] addr_q, addr_d;
  logic rw_q, rw_d, rdy_q, rdy_d, sda_oe_q, sda_oe_d;
  logic addressed_q, addressed_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  i2c_bus_sync u_scl (.Clk(Clk), .Rst(Rst), .d(Scl), .q(scl_s), .rise(scl_rise), .fall(scl_fall));
  i2c_bus_sync u_sda (.Clk(Clk), .Rst(Rst), .d(Sda), .q(sda_s), .rise(sda_rise), .fall(sda_fall));
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign rx_next   = {sda_s, rx_shift_q[7:1]};
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign addr_match = (addr_q == OWN) || (addr_q == '0 && sda_s);
`else
  assign addr_match = addr_q == OWN;
`endif
  // Ack phases use cnt: 0 = waiting for the fall to drive, 1 = driving, 2 = ninth rise seen.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    tx_byte_d   = tx_byte_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    if (stop_det || start_det) begin
      state_d     = stop_det ? IDLE : GETADDR;
      cnt_d       = '0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        GETADDR:
          if (scl_rise) begin
            if (cnt_q == 8'(ADDRESSLENGTH)) begin
              rw_d    = sda_s;
              cnt_d   = '0;
              state_d = addr_match ? ADDRACK : WAITSTOP;
            end else begin
              addr_d = ADDRESSLENGTH'({sda_s, addr_q} >> 1);
              cnt_d  = cnt_q + 8'd1;
            end
          end
        ADDRACK:
          if (scl_rise) cnt_d = cnt_q + 8'd1;
          else if (scl_fall && cnt_q == '0) begin
            sda_oe_d    = 1'b1;
            addressed_d = 1'b1;
            cnt_d       = 8'd1;
          end else if (scl_fall && cnt_q == 8'd2) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d  = GETDATA;
              sda_oe_d = 1'b0;
            end else begin
              state_d   = SENDDATA;
              tx_req_d  = 1'b1;
              tx_byte_d = TxData;
              sda_oe_d  = ~TxData[0];
            end
          end
        GETDATA:
          if (scl_rise) begin
            rx_shift_d = rx_next;
            cnt_d      = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              rdy_d      = RxReady;
              cnt_d      = '0;
              state_d    = DATAACK;
            end
          end
        DATAACK:
          if (scl_rise) cnt_d = cnt_q + 8'd1;
          else if (scl_fall && cnt_q == '0) begin
            sda_oe_d = rdy_q;
            cnt_d    = 8'd1;
            state_d  = rdy_q ? DATAACK : WAITSTOP;
          end else if (scl_fall && cnt_q == 8'd2) begin
            state_d  = GETDATA;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        SENDDATA:
          if (scl_rise) cnt_d = cnt_q + 8'd1;
          else if (scl_fall && cnt_q != '0) begin
            if (cnt_q == 8'd8) begin
              state_d  = GETACK;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end else sda_oe_d = ~tx_byte_q[cnt_q[2:0]];
          end
        GETACK:
          if (scl_rise) begin
            cnt_d   = 8'd1;
            state_d = (sda_s == NACK) ? WAITSTOP : GETACK;
          end else if (scl_fall && cnt_q == 8'd1) begin
            state_d   = SENDDATA;
            tx_req_d  = 1'b1;
            tx_byte_d = TxData;
            sda_oe_d  = ~TxData[0];
            cnt_d     = '0;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rdy_q       <= 1'b0;
      tx_byte_q   <= '0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      tx_byte_q   <= tx_byte_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
    end
  assign Sda       = sda_oe_q ? ACK : 1'bz;
  assign RxData    = rx_data_q;
  assign RxValid   = rx_valid_q;
  assign TxReq     = tx_req_q;
  assign Addressed = addressed_q;
  assign State     = state_q;
endmodule

// File: tb/tb_i2c_slave_target.sv
// tb_i2c_slave_target: directed bus-master sequences against i2c_slave_target with hand-computed expectations.
module tb_i2c_slave_target;
  logic clk = 1'b0, rst_n = 1'b1, scl_m = 1'b1, sda_m = 1'b1, rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h3C;
  wire sda_w;
  logic [7:0] rx_data;
  logic rx_valid, tx_req, addressed;
  logic [3:0] state;
  int n_run = 0, n_fail = 0, rxv_cnt = 0, txr_cnt = 0, drv_cnt = 0;
  pullup(sda_w);
  assign sda_w = sda_m ? 1'bz : 1'b0;
  i2c_slave_target dut (
    .Clk(clk), .Rst(rst_n), .Scl(scl_m), .Sda(sda_w),
    .RxData(rx_data), .RxValid(rx_valid), .RxReady(rx_ready),
    .TxData(tx_data), .TxReq(tx_req), .Addressed(addressed), .State(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (tx_req) txr_cnt++;
    if (sda_m && !sda_w) drv_cnt++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c;
    sda_m = 1'b1; scl_m = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b0; wait_clk(4);
  endtask
  task automatic stop_c;
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    sda_m = 1'b1; wait_clk(4);
  endtask
  task automatic xfer_bit(input logic b, output logic s);
    sda_m = b; wait_clk(4);
    scl_m = 1'b1; wait_clk(2);
    s = sda_w; wait_clk(2);
    scl_m = 1'b0; wait_clk(4);
  endtask
  task automatic addr_bits(input logic [6:0] a, input logic rw);
    logic s;
    for (int i = 0; i < 7; i++) xfer_bit(a[i], s);
    xfer_bit(rw, s);
  endtask
  task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack);
    addr_bits(a, rw);
    xfer_bit(1'b1, ack);
  endtask
  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) xfer_bit(v[i], s);
    xfer_bit(1'b1, ack);
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] v);
    logic s;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, s);
      v[i] = s;
    end
    xfer_bit(mack, s);
  endtask
  initial begin
    logic a, s;
    logic [7:0] v;
    logic [3:0] nib;
    int b0, d0, t0;
    wait_clk(1);
    rst_n = 1'b0;
    wait_clk(3);
    check("rst_state", state, 0);
    check("rst_rxdata", rx_data, 0);
    check("rst_rxvalid", rx_valid, 0);
    check("rst_txreq", tx_req, 0);
    check("rst_addressed", addressed, 0);
    check("rst_sda", sda_w, 1);
    rst_n = 1'b1;
    wait_clk(4);
    // write 0xA5
    b0 = rxv_cnt;
    start_c();
    check("wr_getaddr", state, 1);
    send_addr(7'h2A, 1'b1, a);
    check("wr_addr_ack", a, 0);
    check("wr_addressed", addressed, 1);
    check("wr_getdata", state, 3);
    send_byte(8'hA5, a);
    check("wr_data_ack", a, 0);
    check("wr_rxdata", rx_data, 8'hA5);
    check("wr_rxvalid_cnt", rxv_cnt - b0, 1);
    check("wr_after_ack", state, 3);
    stop_c();
    check("wr_idle", state, 0);
    check("wr_addressed_clr", addressed, 0);
    // read 0x3C twice, master ACK then NACK
    t0 = txr_cnt;
    start_c();
    send_addr(7'h2A, 1'b0, a);
    check("rd_addr_ack", a, 0);
    check("rd_senddata", state, 5);
    check("rd_txreq1", txr_cnt - t0, 1);
    read_byte(1'b0, v);
    check("rd_byte1", v, 8'h3C);
    check("rd_txreq2", txr_cnt - t0, 2);
    check("rd_send_again", state, 5);
    read_byte(1'b1, v);
    check("rd_byte2", v, 8'h3C);
    check("rd_waitstop", state, 7);
    check("rd_txreq_total", txr_cnt - t0, 2);
    stop_c();
    check("rd_idle", state, 0);
    // address mismatch
    d0 = drv_cnt;
    start_c();
    send_addr(7'h11, 1'b1, a);
    check("mm_nack", a, 1);
    check("mm_waitstop", state, 7);
    send_byte(8'h00, a);
    check("mm_still_wait", state, 7);
    check("mm_addressed", addressed, 0);
    check("mm_never_driven", drv_cnt - d0, 0);
    stop_c();
    check("mm_idle", state, 0);
    // backpressure
    rx_ready = 1'b0;
    b0 = rxv_cnt;
    start_c();
    send_addr(7'h2A, 1'b1, a);
    check("bp_addr_ack", a, 0);
    send_byte(8'h5A, a);
    check("bp_data_nack", a, 1);
    check("bp_waitstop", state, 7);
    check("bp_rxdata", rx_data, 8'h5A);
    check("bp_rxvalid_cnt", rxv_cnt - b0, 1);
    stop_c();
    rx_ready = 1'b1;
    // all-zero address
    start_c();
    send_addr(7'h00, 1'b1, a);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    check("gc_ack", a, 0);
`else
    check("gc_nack", a, 1);
`endif
    stop_c();
    // repeated START mid read byte
    start_c();
    send_addr(7'h2A, 1'b0, a);
    for (int i = 0; i < 4; i++) begin
      xfer_bit(1'b1, s);
      nib[i] = s;
    end
    check("rs_nibble", nib, 4'hC);
    scl_m = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(3);
    check("rs_getaddr", state, 1);
    check("rs_released", dut.sda_oe_q, 0);
    check("rs_addressed_clr", addressed, 0);
    scl_m = 1'b0; wait_clk(4);
    send_addr(7'h2A, 1'b1, a);
    check("rs_addr_ack", a, 0);
    send_byte(8'h77, a);
    check("rs_data_ack", a, 0);
    check("rs_rxdata", rx_data, 8'h77);
    stop_c();
    // reset during ADDRACK
    start_c();
    addr_bits(7'h2A, 1'b1);
    check("ra_addrack", state, 2);
    check("ra_sda_driven", sda_w, 0);
    b0 = rxv_cnt;
    scl_m = 1'b1; wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("ra_sda_released", sda_w, 1);
    check("ra_state", state, 0);
    check("ra_addressed", addressed, 0);
    wait_clk(4);
    check("ra_no_rxvalid", rxv_cnt - b0, 0);
    rst_n = 1'b1;
    wait_clk(4);
    // bus ignored without a START after reset
    d0 = drv_cnt;
    scl_m = 1'b0; wait_clk(4);
    for (int i = 0; i < 9; i++) xfer_bit(i[0], s);
    check("post_rst_idle", state, 0);
    check("post_rst_no_drive", drv_cnt - d0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_target.md
I2C_SLAVE_TARGET -- requirements
Module: i2c_slave_target

Interface
REQ-001 SHALL have parameter ADDRESSLENGTH, default 7, giving the slave address width in bits.
REQ-002 SHALL have parameter OWN_ADDRESS, default 'h2A, giving the address this slave answers to.
REQ-003 SHALL have port Clk, input, 1, system clock; all logic on posedge Clk; Clk >= 8x Scl frequency.
REQ-004 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Scl, input, 1, bus clock driven by the master.
REQ-006 SHALL have port Sda, inout, 1, open-drain data line, driven only as 0 or z.
REQ-007 SHALL have port RxData, output, 8, last byte written by the master.
REQ-008 SHALL have port RxValid, output, 1, one-Clk pulse when RxData is updated.
REQ-009 SHALL have port RxReady, input, 1, high = user accepts the next write byte; sampled on the 8th data bit.
REQ-010 SHALL have port TxData, input, 8, byte to return on a master read; sampled when TxReq pulses.
REQ-011 SHALL have port TxReq, output, 1, one-Clk pulse requesting TxData for the next read byte.
REQ-012 SHALL have port Addressed, output, 1, high from address ACK until STOP or repeated START.
REQ-013 SHALL have port State, output, 4, current FSM state encoding.

Function
REQ-014 SHALL synchronise Scl and Sda through 2 flops and derive rise/fall strobes; all bus events are judged on synchronised values.
REQ-015 SHALL detect START as synchronised Sda falling while Scl high, and STOP as Sda rising while Scl high, from every state.
REQ-016 SHALL sample Sda on Scl rise and change its own Sda drive only on the Clk after Scl fall.
REQ-017 SHALL use FSM states IDLE, GETADDR, ADDRACK, GETDATA, DATAACK, SENDDATA, GETACK, WAITSTOP.
REQ-018 SHALL go to GETADDR on START from any state; to IDLE on STOP from any state; a STOP wins over a same-cycle bit sample.
REQ-019 SHALL receive ADDRESSLENGTH address bits LSB first (bit 0 first), then one RorW bit, where 1 = master writes and 0 = master reads.
REQ-020 SHALL on address match drive ACK (Sda=0) in ADDRACK, assert Addressed, and on mismatch release Sda and go to WAITSTOP.
REQ-021 SHALL after ADDRACK go to GETDATA if RorW=1, else pulse TxReq, latch TxData, and go to SENDDATA.
REQ-022 SHALL in GETDATA shift 8 bits LSB first, and after the 8th bit update RxData, pulse RxValid and enter DATAACK; the whole byte is 8 Scl rises.
REQ-023 SHALL in DATAACK drive ACK if RxReady=1, else NACK (release Sda) and go to WAITSTOP; on ACK return to GETDATA.
REQ-024 SHALL in SENDDATA drive the latched byte LSB first, then enter GETACK with Sda released.
REQ-025 SHALL in GETACK, on sampled ACK (0), pulse TxReq, latch TxData and return to SENDDATA; on NACK (1) go to WAITSTOP.
REQ-026 SHALL handle a byte count that is unbounded; the transfer ends only by STOP, repeated START, or NACK.
REQ-027 SHALL release Sda in IDLE, GETADDR, GETDATA, GETACK and WAITSTOP.
REQ-028 SHALL encode State as IDLE=0, GETADDR=1, ADDRACK=2, GETDATA=3, DATAACK=4, SENDDATA=5, GETACK=6, WAITSTOP=7.

Reset
REQ-029 SHALL while Rst=0 asynchronously force State=IDLE, Sda=z, RxData=0, RxValid=0, TxReq=0, Addressed=0, bit counter=0, and synchroniser flops=1.
REQ-030 SHALL after Rst release ignore the bus until the first START; a reset mid-transfer abandons the transfer without a false RxValid.

Configuration
REQ-031 SHALL, with I2C_SLAVE_GENERAL_CALL_EN defined, also ACK all-zero address with RorW=1 and deliver the following bytes via RxData/RxValid.
REQ-032 SHALL, without I2C_SLAVE_GENERAL_CALL_EN, treat the all-zero address as a mismatch.

Structure
REQ-033 SHALL take state encodings and ACK=0/NACK=1 constants from shared package i2c_pkg, which is also usable by the master.
REQ-034 SHALL instantiate sub-module i2c_bus_sync (2-flop synchroniser plus rise/fall strobes) once for Scl and once for Sda.

Verification
REQ-035 SHALL verify this write: START, addr 'h2A, RorW=1, byte 'hA5, RxReady=1, STOP -> addr ACK, RxData='hA5, one RxValid pulse, data ACK, IDLE.
REQ-036 SHALL verify this read: START, addr 'h2A, RorW=0, TxData='h3C, master ACK then NACK -> bus shows 'h3C LSB first twice, TxReq pulses twice, then WAITSTOP.
REQ-037 SHALL verify this mismatch: START, addr 'h11 -> Sda never driven, Addressed=0, WAITSTOP until STOP.
REQ-038 SHALL verify this backpressure case: write with RxReady=0 at byte end -> NACK on ninth clock, WAITSTOP.
REQ-039 SHALL verify this repeated START: START in mid-byte of a read -> GETADDR, Sda released within 3 Clk.
REQ-040 SHALL verify this reset: Rst=0 during ADDRACK -> Sda=z immediately, State=0, and no RxValid pulse.
